// File: rtl/controller_sequencer_pkg.sv
// SAP-1 shared definitions: opcodes, one-hot T-states, control-word bit positions.
// No logic; latency and backpressure n/a.
package sap1_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_LDA = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB = 4'h2;
  localparam logic [OP_W-1:0] OP_OUT = 4'hE;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  localparam int T_W = 6;

  typedef enum logic [T_W-1:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  typedef enum int unsigned {
    CP = 0, EP = 1, LM = 2, CE = 3, LI = 4, EI = 5,
    LA = 6, EA = 7, LB = 8, SU = 9, EU = 10, LO = 11
  } ctrl_idx_e;

  localparam int CTRL_W = 12;

  typedef logic [CTRL_W-1:0] ctrl_word_t;

endpackage

// File: rtl/controller_sequencer_if.sv
// Control bundle between the sequencer (master) and the datapath (slave).
// Purely combinational wires; no latency, no backpressure.
interface controller_sequencer_if;
  import sap1_pkg::*;

  logic [OP_W-1:0] opcode;
  logic [T_W-1:0]  t_state;
  logic cp, ep, lm, ce, li, ei, la, ea, lb, su, eu, lo;
  logic hlt;

  modport master (
    input  opcode,
    output t_state, cp, ep, lm, ce, li, ei, la, ea, lb, su, eu, lo, hlt
  );

  modport slave (
    output opcode,
    input  t_state, cp, ep, lm, ce, li, ei, la, ea, lb, su, eu, lo, hlt
  );

endinterface

// File: rtl/controller_sequencer_ring.sv
// One-hot T1..T6 ring counter; advances every edge unless hold, clr returns to T1.
// State visible same cycle; hold freezes the ring (used for halt).
module ring_counter
  import sap1_pkg::*;
(
  input  logic           clk_n,
  input  logic           clr,
  input  logic           hold,
  output logic [T_W-1:0] t_state
);

  tstate_e state_q, state_d;

  always_ff @(posedge clk_n) begin
    if (clr) state_q <= T1;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!hold) begin
      case (state_q)
        T1:      state_d = T2;
        T2:      state_d = T3;
        T3:      state_d = T4;
        T4:      state_d = T5;
        T5:      state_d = T6;
        T6:      state_d = T1;
        default: state_d = T1;
      endcase
    end
  end

  assign t_state = state_q;

endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 control unit: ring counter plus combinational opcode decode of all W-bus controls.
// Controls valid in the same T-state (zero latency); halt freezes sequencing until clr.
module controller_sequencer
  import sap1_pkg::*;
(
  input  logic                   clk_n,
  input  logic                   clr,
  controller_sequencer_if.master bus
);

  logic [T_W-1:0] t_state;
  logic           halted_q;
  logic           halt_now;
  ctrl_word_t     ctrl;

  // Halt is taken on the T4 edge itself, so the ring must not advance past T4.
  assign halt_now = (t_state == T4) && (bus.opcode == OP_HLT) && !halted_q;

  ring_counter u_ring (
    .clk_n   (clk_n),
    .clr     (clr),
    .hold    (halted_q || halt_now),
    .t_state (t_state)
  );

  always_ff @(posedge clk_n) begin
    if (clr)           halted_q <= 1'b0;
    else if (halt_now) halted_q <= 1'b1;
  end

  // Halted gating matters: opcode may wander while frozen in T4.
  always_comb begin
    ctrl = '0;
    if (!clr && !halted_q) begin
      case (t_state)
        T1: begin
          ctrl[EP] = 1'b1;
          ctrl[LM] = 1'b1;
        end
        T2: ctrl[CP] = 1'b1;
        T3: begin
          ctrl[CE] = 1'b1;
          ctrl[LI] = 1'b1;
        end
        T4: begin
          if (bus.opcode == OP_LDA || bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            ctrl[EI] = 1'b1;
            ctrl[LM] = 1'b1;
          end else if (bus.opcode == OP_OUT) begin
            ctrl[EA] = 1'b1;
            ctrl[LO] = 1'b1;
          end
        end
        T5: begin
          if (bus.opcode == OP_LDA) begin
            ctrl[CE] = 1'b1;
            ctrl[LA] = 1'b1;
          end else if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            ctrl[CE] = 1'b1;
            ctrl[LB] = 1'b1;
          end
        end
        T6: begin
          if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            ctrl[EU] = 1'b1;
            ctrl[LA] = 1'b1;
            ctrl[SU] = (bus.opcode == OP_SUB);
          end
        end
        default: ctrl = '0;
      endcase
    end
  end

  assign bus.t_state = t_state;
  assign bus.hlt     = halted_q;
  assign bus.cp      = ctrl[CP];
  assign bus.ep      = ctrl[EP];
  assign bus.lm      = ctrl[LM];
  assign bus.ce      = ctrl[CE];
  assign bus.li      = ctrl[LI];
  assign bus.ei      = ctrl[EI];
  assign bus.la      = ctrl[LA];
  assign bus.ea      = ctrl[EA];
  assign bus.lb      = ctrl[LB];
  assign bus.su      = ctrl[SU];
  assign bus.eu      = ctrl[EU];
  assign bus.lo      = ctrl[LO];

endmodule

// File: doc/controller_sequencer.md
Name: controller_sequencer

Overview:
- SAP-1 control unit: a 6-state one-hot ring counter (T1..T6) plus an opcode decoder.
- Drives every load and enable line on the W bus, including cp/ep into program_counter and lm into the MAR.
- Sits between the instruction register (opcode source) and all datapath registers.
- It is the initiator of the fetch/execute protocol that program_counter, MAR, RAM, IR, A, B, ALU and output register respond to.

Parameters:
- OP_W, 4, opcode width (upper nibble of IR).
- OP_LDA, 4'h0, load accumulator from memory.
- OP_ADD, 4'h1, A <= A + B(mem).
- OP_SUB, 4'h2, A <= A - B(mem).
- OP_OUT, 4'hE, output register <= A.
- OP_HLT, 4'hF, halt clock sequencing.

Ports:
- clk_n  in  1  system clock; all state changes on its rising edge.
- clr  in  1  synchronous active-high reset.
- opcode  in  OP_W  IR upper nibble; valid from T4 onward.
- t_state  out  6  one-hot ring state; bit0=T1 .. bit5=T6.
- cp  out  1  program_counter increment.
- ep  out  1  program_counter drive W bus.
- lm  out  1  MAR load.
- ce  out  1  RAM drive W bus.
- li  out  1  IR load.
- ei  out  1  IR operand drive W bus.
- la  out  1  A load.
- ea  out  1  A drive W bus.
- lb  out  1  B load.
- su  out  1  ALU subtract select.
- eu  out  1  ALU drive W bus.
- lo  out  1  output register load.
- hlt  out  1  halted flag.

Behaviour:
- Reset:
  - clr=1 at a clk_n rising edge sets t_state=6'b000001 (T1) and clears the halted flag.
  - While clr=1, all control outputs are forced to 0 combinationally, including ep/lm.
- Ring advance: each rising edge moves T1->T2->...->T6->T1, except when halted or in reset.
- Decode: control outputs are combinational from (t_state, opcode), gated by ~clr. Zero added latency; each output is valid for the full T-state.
- Fetch, opcode-independent:
  - T1: ep, lm.
  - T2: cp.
  - T3: ce, li.
- T4:
  - LDA/ADD/SUB: ei, lm.
  - OUT: ea, lo.
  - HLT: no loads/enables asserted.
  - Undefined opcode: all 0 (NOP).
- T5:
  - LDA: ce, la.
  - ADD/SUB: ce, lb.
  - Others: all 0.
- T6:
  - ADD: eu, la.
  - SUB: eu, su, la.
  - Others: all 0.
- su is asserted only in T6 of SUB, never otherwise.
- Halt:
  - In T4 with opcode==OP_HLT, the next rising edge sets the halted flag, and hlt=1 from then on.
  - While halted, t_state stays at T4 and all control outputs are 0.
  - Only clr exits the halt state.
- Exclusivity: at most one W-bus driver (ep, ce, ei, ea, eu) is high in any cycle. The bench checks this as an assertion.
- clr mid-instruction: the next edge returns to T1 with no partial completion. cp is not pulsed after the clear unless T2 is reached again.
- clr and HLT opcode at the same edge: clr wins; hlt=0, T1.
- opcode changes during T1-T3 have no effect on outputs.

Decomposition:
- Shared package sap1_pkg holds:
  - opcode constants (OP_LDA..OP_HLT);
  - T-state one-hot constants (T1..T6);
  - a control-word bit index enum (CP, EP, LM, CE, LI, EI, LA, EA, LB, SU, EU, LO).
- Natural sub-module: ring_counter. It contains the 6-bit one-hot state register, clr and hold inputs, and t_state output.
- Decode stays in controller_sequencer.

Test Plan:
- clr=1 for 3 cycles, then release -> t_state=000001 during reset, all outputs 0. First post-reset cycle ep=lm=1, next cycle cp=1, next ce=li=1.
- opcode=4'h0 (LDA) held -> T4 ei=lm=1; T5 ce=la=1; T6 all 0; following cycle t_state=000001.
- opcode=4'h2 (SUB) -> T6 eu=su=la=1. Repeat with 4'h1 (ADD) -> T6 eu=la=1, su=0.
- opcode=4'hE (OUT) -> T4 ea=lo=1; T5 and T6 all 0. Opcode 4'h7 -> T4-T6 all 0.
- opcode=4'hF (HLT) -> after the T4 edge, hlt=1 and t_state=001000 for 20 cycles with all outputs 0. Then clr pulse -> hlt=0, T1.
- clr asserted in T5 of an ADD -> next cycle t_state=000001, lb never asserted after the clear. Across the full run, the bus-driver one-hot-or-zero check never fails.
